// File: rtl/e_mdu_pkg.sv
// Shared opcodes, FSM state type and op-class helpers for the E-stage multiply/divide unit.
// MDU_MADD_EN turns the madd/msub codes into real accumulate ops; otherwise they decode as no-ops.
package e_mdu_pkg;

   localparam logic [3:0] MDU_NOP   = 4'd0;
   localparam logic [3:0] MDU_MULT  = 4'd1;
   localparam logic [3:0] MDU_MULTU = 4'd2;
   localparam logic [3:0] MDU_DIV   = 4'd3;
   localparam logic [3:0] MDU_DIVU  = 4'd4;
   localparam logic [3:0] MDU_MTHI  = 4'd5;
   localparam logic [3:0] MDU_MTLO  = 4'd6;
   localparam logic [3:0] MDU_MADD  = 4'd7;
   localparam logic [3:0] MDU_MADDU = 4'd8;
   localparam logic [3:0] MDU_MSUB  = 4'd9;
   localparam logic [3:0] MDU_MSUBU = 4'd10;

   typedef enum logic {S_IDLE, S_BUSY} state_e;

   // Ops that occupy the unit for MULT_CYCLES
   function automatic logic is_mul(input logic [3:0] op);
      logic r;
      r = (op == MDU_MULT) || (op == MDU_MULTU);
`ifdef MDU_MADD_EN
      r = r || (op == MDU_MADD) || (op == MDU_MADDU) || (op == MDU_MSUB) || (op == MDU_MSUBU);
`endif
      return r;
   endfunction

   function automatic logic is_div(input logic [3:0] op);
      return (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

endpackage

// File: rtl/e_mdu_arith.sv
// Combinational datapath for the MDU: 64-bit product, signed/unsigned divide, optional accumulate.
// Accumulate forms exist only when MDU_MADD_EN is defined.
module e_mdu_arith
   import e_mdu_pkg::*;
(
   input  logic [31:0] in1,
   input  logic [31:0] in2,
   input  logic [3:0]  md_op,
   input  logic [31:0] hi,
   input  logic [31:0] lo,
   output logic [63:0] result,
   output logic        div0
);

   logic        sgn;
   logic [63:0] ext1, ext2, prod;
   logic [31:0] a_mag, b_mag, divisor, q_mag, r_mag, quo, rem;

   always_comb begin
      sgn = (md_op == MDU_MULT) || (md_op == MDU_DIV);
`ifdef MDU_MADD_EN
      sgn = sgn || (md_op == MDU_MADD) || (md_op == MDU_MSUB);
`endif
      // Low 64 bits of the product of sign-extended operands equal the signed product
      ext1 = sgn ? {{32{in1[31]}}, in1} : {32'd0, in1};
      ext2 = sgn ? {{32{in2[31]}}, in2} : {32'd0, in2};
      prod = ext1 * ext2;

      div0    = is_div(md_op) && (in2 == 32'd0);
      a_mag   = (sgn && in1[31]) ? -in1 : in1;
      b_mag   = (sgn && in2[31]) ? -in2 : in2;
      divisor = (b_mag == 32'd0) ? 32'd1 : b_mag;
      q_mag   = a_mag / divisor;
      r_mag   = a_mag % divisor;
      quo     = (sgn && (in1[31] ^ in2[31])) ? -q_mag : q_mag;
      rem     = (sgn && in1[31]) ? -r_mag : r_mag;

      result = {hi, lo};
      case (md_op)
         MDU_MULT, MDU_MULTU: result = prod;
         MDU_DIV,  MDU_DIVU:  result = {rem, quo};
`ifdef MDU_MADD_EN
         MDU_MADD, MDU_MADDU: result = {hi, lo} + prod;
         MDU_MSUB, MDU_MSUBU: result = {hi, lo} - prod;
`endif
         default:             result = {hi, lo};
      endcase
   end

endmodule

// File: rtl/e_mdu_ctrl.sv
// E-stage multiply/divide sequencer: owns HI/LO, holds busy while a launched op counts down.
// Build option MDU_MADD_EN enables madd/maddu/msub/msubu.
module e_mdu_ctrl
   import e_mdu_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] in1,
   input  logic [31:0] in2,
   input  logic [3:0]  md_op,
   input  logic        md_start,
   input  logic        flush_req,
   input  logic        rd_hi,
   output logic        busy,
   output logic [31:0] md_out,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       hi_q, hi_d, lo_q, lo_d;
   logic [63:0]       pend_q, pend_d;
   logic              pend_wr_q, pend_wr_d;
   logic [63:0]       arith_res;
   logic              arith_div0;
   logic              go;

   e_mdu_arith u_arith (
      .in1    (in1),
      .in2    (in2),
      .md_op  (md_op),
      .hi     (hi_q),
      .lo     (lo_q),
      .result (arith_res),
      .div0   (arith_div0)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      pend_d    = pend_q;
      pend_wr_d = pend_wr_q;
      go        = md_start && !flush_req && (state_q == S_IDLE);

      case (state_q)
         S_IDLE: begin
            if (go) begin
               if (is_mul(md_op)) begin
                  pend_d    = arith_res;
                  pend_wr_d = 1'b1;
                  cnt_d     = CNT_W'(MULT_CYCLES);
                  state_d   = S_BUSY;
               end else if (is_div(md_op)) begin
                  // Divide by zero still burns the full latency but leaves HI/LO alone
                  if (!arith_div0) pend_d = arith_res;
                  pend_wr_d = !arith_div0;
                  cnt_d     = CNT_W'(DIV_CYCLES);
                  state_d   = S_BUSY;
               end else if (md_op == MDU_MTHI) begin
                  hi_d = in1;
               end else if (md_op == MDU_MTLO) begin
                  lo_d = in1;
               end
            end
         end
         S_BUSY: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               if (pend_wr_q) {hi_d, lo_d} = pend_q;
               pend_wr_d = 1'b0;
               state_d   = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         pend_q    <= '0;
         pend_wr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         pend_q    <= pend_d;
         pend_wr_q <= pend_wr_d;
      end
   end

   // Issue-cycle term lets the hazard unit stall the very next HI/LO user
   assign busy   = (md_start && (is_mul(md_op) || is_div(md_op)) && !flush_req) || (state_q == S_BUSY);
   assign md_out = rd_hi ? hi_q : lo_q;
   assign hi     = hi_q;
   assign lo     = lo_q;

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Directed bench for e_mdu_ctrl: latency, results, flush, reset abort and held-op ordering.
module tb_e_mdu_ctrl;
   import e_mdu_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] in1 = '0, in2 = '0;
   logic [3:0]  md_op = MDU_NOP;
   logic        md_start = 1'b0, flush_req = 1'b0, rd_hi = 1'b0;
   logic        busy;
   logic [31:0] md_out, hi, lo;
   int          passed = 0, failed = 0, total = 0;
   int          n;

   always #5 clk = ~clk;

   e_mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .in1(in1), .in2(in2), .md_op(md_op),
      .md_start(md_start), .flush_req(flush_req), .rd_hi(rd_hi),
      .busy(busy), .md_out(md_out), .hi(hi), .lo(lo)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Issue op, then present hold_op from the first edge on; n = cycles busy was high (bounded)
   task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] hold_op, input logic [31:0] hold_a, output int cyc);
      md_op = op; in1 = a; in2 = b; md_start = 1'b1;
      #1;
      cyc = 0;
      while (busy === 1'b1 && cyc < 50) begin
         cyc++;
         @(posedge clk);
         #1;
         md_op = hold_op; in1 = hold_a; md_start = (hold_op != MDU_NOP);
         #1;
      end
   endtask

   initial begin
      tick();
      tick();
      chk("reset_hi", hi, 32'h0);
      chk("reset_lo", lo, 32'h0);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      reset = 1'b0;

      run(MDU_MULT, 32'hFFFF_FFFE, 32'd3, MDU_NOP, 32'd0, n);
      chk("mult_busy_cycles", n, 32'd6);
      chk("mult_hi", hi, 32'hFFFF_FFFF);
      chk("mult_lo", lo, 32'hFFFF_FFFA);

      run(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MDU_NOP, 32'd0, n);
      chk("multu_busy_cycles", n, 32'd6);
      chk("multu_hi", hi, 32'hFFFF_FFFE);
      chk("multu_lo", lo, 32'h0000_0001);

      run(MDU_DIVU, 32'd100, 32'd7, MDU_NOP, 32'd0, n);
      chk("divu_busy_cycles", n, 32'd11);
      chk("divu_hi", hi, 32'd2);
      chk("divu_lo", lo, 32'd14);
      rd_hi = 1'b1; #1;
      chk("md_out_hi", md_out, 32'd2);
      rd_hi = 1'b0; #1;
      chk("md_out_lo", md_out, 32'd14);

      run(MDU_DIV, 32'hFFFF_FFF9, 32'd2, MDU_NOP, 32'd0, n);
      chk("div_busy_cycles", n, 32'd11);
      chk("div_hi", hi, 32'hFFFF_FFFF);
      chk("div_lo", lo, 32'hFFFF_FFFD);

      run(MDU_DIV, 32'd5, 32'd0, MDU_NOP, 32'd0, n);
      chk("div0_busy_cycles", n, 32'd11);
      chk("div0_hi", hi, 32'hFFFF_FFFF);
      chk("div0_lo", lo, 32'hFFFF_FFFD);

      run(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, MDU_NOP, 32'd0, n);
      chk("ovf_busy_cycles", n, 32'd11);
      chk("ovf_hi", hi, 32'h0);
      chk("ovf_lo", lo, 32'h8000_0000);

      // Flushed mult and mthi must leave no trace
      md_op = MDU_MULT; in1 = 32'd5; in2 = 32'd5; md_start = 1'b1; flush_req = 1'b1;
      #1;
      chk("flush_busy_issue", {31'd0, busy}, 32'd0);
      tick();
      chk("flush_busy_after", {31'd0, busy}, 32'd0);
      chk("flush_mult_hi", hi, 32'h0);
      chk("flush_mult_lo", lo, 32'h8000_0000);
      md_op = MDU_MTHI; in1 = 32'h1234;
      tick();
      chk("flush_mthi_hi", hi, 32'h0);
      md_start = 1'b0; flush_req = 1'b0;

      md_op = 4'd15; md_start = 1'b1;
      #1;
      chk("unknown_busy", {31'd0, busy}, 32'd0);
      tick();
      md_start = 1'b0;
      chk("unknown_hi", hi, 32'h0);
      chk("unknown_lo", lo, 32'h8000_0000);

      md_op = MDU_MTHI; in1 = 32'h0; md_start = 1'b1;
      tick();
      md_op = MDU_MTLO; in1 = 32'hFFFF_FFFF;
      tick();
      md_start = 1'b0;
      chk("mtlo_lo", lo, 32'hFFFF_FFFF);
`ifdef MDU_MADD_EN
      run(MDU_MADDU, 32'd1, 32'd1, MDU_NOP, 32'd0, n);
      chk("maddu_busy_cycles", n, 32'd6);
      chk("maddu_hi", hi, 32'd1);
      chk("maddu_lo", lo, 32'd0);
`else
      md_op = MDU_MADDU; in1 = 32'd1; in2 = 32'd1; md_start = 1'b1;
      #1;
      chk("maddu_nop_busy", {31'd0, busy}, 32'd0);
      tick();
      md_start = 1'b0;
      chk("maddu_nop_hi", hi, 32'h0);
      chk("maddu_nop_lo", lo, 32'hFFFF_FFFF);
`endif

      // mtlo held behind a running mult lands one cycle after the commit
      run(MDU_MULT, 32'd2, 32'd3, MDU_MTLO, 32'h55, n);
      chk("held_busy_cycles", n, 32'd6);
      chk("held_commit_hi", hi, 32'h0);
      chk("held_commit_lo", lo, 32'd6);
      tick();
      md_start = 1'b0;
      chk("held_mtlo_lo", lo, 32'h55);

      // Reset in the fourth BUSY cycle aborts the divide
      md_op = MDU_DIVU; in1 = 32'd100; in2 = 32'd7; md_start = 1'b1;
      tick();
      md_start = 1'b0;
      tick(); tick(); tick();
      chk("abort_busy_before", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_hi", hi, 32'h0);
      chk("abort_lo", lo, 32'h0);
      repeat (12) tick();
      chk("abort_no_commit_lo", lo, 32'h0);
      md_op = MDU_MTLO; in1 = 32'hABCD; md_start = 1'b1;
      tick();
      md_start = 1'b0;
      chk("post_reset_mtlo", lo, 32'hABCD);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
